uart_reg_ctrl: RTL
==================

# uart_reg_ctrl

16550-style register controller for the UART: decodes byte-wide host register accesses, holds FCR/LCR/SCR/IER/divisor state, tracks LSR status and prioritises interrupts. It sits between the host bus and the UART datapath (RX/TX FIFOs, baud generator). It exports the composed CSR and divisor structs and sequences FIFO pushes, pops and resets.

## Interface
- DIV_RST, 16'h0001, divisor value after reset
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid / req_write  in  1  request strobe / 1 = write
- req_addr  in  3  register offset
- req_wdata  in  8  write data
- req_ready  out  1  controller can accept a request
- rsp_valid  out  1  one-cycle response strobe (reads and writes)
- rsp_rdata  out  8  read data, valid with rsp_valid, 0 for writes
- rx_data  in  8  RX FIFO head; rx_empty  in  1; rx_pop  out  1  pop pulse
- tx_data  out  8; tx_push  out  1  push pulse; tx_full, tx_empty, tx_shift_idle  in  1
- rx_pe, rx_fe, rx_bi, rx_oe  in  1  error event pulses; rx_fifo_err  in  1  level, any errored byte in RX FIFO
- fifo_rx_rst, fifo_tx_rst  out  1  one-cycle FIFO reset pulses
- div_load  out  1  pulse: divisor changed, baud generator reloads
- csr  out  csr_t  {fcr, lcr, lsr, scr}; div  out  div_t
- irq  out  1  interrupt request

## Operation
- FSM: IDLE (req_ready=1) → RESP on req_valid&req_ready; RESP (req_ready=0, rsp_valid=1) → IDLE.
- Map with lcr.dlab=0: 0 RBR(r)/THR(w), 1 IER, 2 IIR(r)/FCR(w), 3 LCR, 4 MCR (reads 0, writes ignored), 5 LSR (read-only), 6 MSR (reads 0), 7 SCR. With dlab=1: 0 DLL, 1 DLM; offsets 2–7 are unchanged.
- RBR read: rdata=rx_data and rx_pop pulses if !rx_empty; else rdata=0, no pop.
- THR write: tx_data=wdata, tx_push pulses if !tx_full; else byte dropped.
- FCR write: stores ena, dma_mode, rx_trigger; reserved bits and stored tx_rst/rx_rst always 0.
  - rx_rst=1 → fifo_rx_rst; tx_rst=1 → fifo_tx_rst.
  - Change of ena → both reset pulses.
- DLL/DLM write updates div and pulses div_load.
- IER[2:0]: bit0 RX data available, bit1 THRE, bit2 line status; upper bits read 0.
- LSR composition:
  - dr = !rx_empty
  - oe/pe/fe/bi sticky: set by pulses, cleared by LSR read
  - thre = tx_empty; temt = tx_empty & tx_shift_idle
  - rx_fifo_error = rx_fifo_err & fcr.ena
- IIR[3:0] priority: 4'h6 line status (IER2 & any of oe/pe/fe/bi) > 4'h4 RX data (IER0 & dr) > 4'h2 THRE (IER1 & thre_pend) > 4'h1 none. IIR[7:6]=2'b11 when fcr.ena.
- thre_pend:
  - Set on tx_empty rising edge, and on IER1 write 0→1 while tx_empty.
  - Cleared by THR write, or by IIR read returning 4'h2.
- irq = (IIR[0]==0), registered.

## Timing
- Request accepted in cycle T. Register state updates at the end of T.
- In T+1: rsp_valid=1, rsp_rdata valid. Side-effect pulses (rx_pop, tx_push, fifo_*_rst, div_load, sticky/thre_pend clears) are asserted in T+1.
- Throughput: one access per 2 cycles.
- Read data is sampled in T from pre-update state. The LSR value returned includes events arriving in T.
- An error pulse in the same cycle as the LSR-read clear wins: the bit stays set.
- Reset values:
  - req_ready=1; all other pulse and strobe outputs 0; rsp_rdata=0; irq=0
  - fcr, lcr, scr, IER 0; sticky bits 0; thre_pend 0; div=DIV_RST
- rst asserted in RESP aborts the access: no rsp_valid and no pulses after release.

## Configuration
- UART_SCR_EN defined: SCR (offset 7) is a read/write 8-bit register, reset 0.
- UART_SCR_EN undefined: offset 7 reads 0, writes are ignored, csr.scr is tied to 0.

## Structure
- Add to the shared package:
  - ier_t (packed 3 bits)
  - IIR code localparams
  - register offset localparams (UART_RBR…UART_SCR)
  - rsp_state_e (IDLE, RESP)
- Sub-module uart_lsr_track holds the sticky error bits, thre_pend and the IIR priority encode.

## Test plan
- Write LCR=8'h80, write offset 0=8'h34 and offset 1=8'h12 → div=16'h1234, two div_load pulses, rsp_valid each T+1; read offset 0 → 8'h34.
- With rx_empty=0, rx_data=8'hA5, read RBR → rdata=8'hA5, rx_pop single pulse in T+1; with rx_empty=1 → rdata=0, no pop.
- Pulse rx_fe with IER=3'b100 → irq=1, IIR read=8'h06. LSR read → bit3=1; second LSR read → bit3=0, irq=0.
- Write FCR=8'h07 → fifo_rx_rst and fifo_tx_rst both pulse in T+1; FCR reads back ena=1, resets 0; IIR[7:6]=2'b11.
- IER=3'b010 with tx_empty=1 → IIR=8'hC2 (FIFO on); IIR read clears it → next IIR read=8'hC1; THR write with tx_full=1 → no tx_push.
- Assert rst during RESP → rsp_valid stays 0, all pulses 0, div=DIV_RST, req_ready=1 after release.

Source files
------------

// File: rtl/uart_reg_ctrl_pkg.sv
// Shared types and constants for the 16550-style UART register controller.
// Register offsets, IIR codes, CSR structs and the response FSM state type.
package uart_reg_ctrl_pkg;

  localparam logic [2:0] UART_RBR = 3'd0;
  localparam logic [2:0] UART_THR = 3'd0;
  localparam logic [2:0] UART_DLL = 3'd0;
  localparam logic [2:0] UART_IER = 3'd1;
  localparam logic [2:0] UART_DLM = 3'd1;
  localparam logic [2:0] UART_IIR = 3'd2;
  localparam logic [2:0] UART_FCR = 3'd2;
  localparam logic [2:0] UART_LCR = 3'd3;
  localparam logic [2:0] UART_MCR = 3'd4;
  localparam logic [2:0] UART_LSR = 3'd5;
  localparam logic [2:0] UART_MSR = 3'd6;
  localparam logic [2:0] UART_SCR = 3'd7;

  localparam logic [3:0] IIR_LSI  = 4'h6;
  localparam logic [3:0] IIR_RDA  = 4'h4;
  localparam logic [3:0] IIR_THRE = 4'h2;
  localparam logic [3:0] IIR_NONE = 4'h1;

  typedef enum logic {IDLE, RESP} rsp_state_e;

  typedef struct packed {
    logic       lsi;
    logic       threi;
    logic       rdai;
  } ier_t;

  typedef struct packed {
    logic [1:0] rx_trigger;
    logic [1:0] rsvd;
    logic       dma_mode;
    logic       tx_rst;
    logic       rx_rst;
    logic       ena;
  } fcr_t;

  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       stick;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    logic       rx_fifo_error;
    logic       temt;
    logic       thre;
    logic       bi;
    logic       fe;
    logic       pe;
    logic       oe;
    logic       dr;
  } lsr_t;

  typedef struct packed {
    fcr_t       fcr;
    lcr_t       lcr;
    lsr_t       lsr;
    logic [7:0] scr;
  } csr_t;

  typedef struct packed {
    logic [7:0] dlm;
    logic [7:0] dll;
  } div_t;

  // Self-clearing reset bits and reserved bits never stick in the stored FCR.
  function automatic fcr_t fcr_store(input logic [7:0] w);
    fcr_t f;
    f            = '0;
    f.ena        = w[0];
    f.dma_mode   = w[3];
    f.rx_trigger = w[7:6];
    return f;
  endfunction

endpackage

// File: rtl/uart_reg_ctrl_lsr_track.sv
// Line-status tracking: sticky error bits, THRE-pending flag, IIR priority
// encoding and the registered interrupt request.
module uart_lsr_track
  import uart_reg_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pe_i,
  input  logic       rx_fe_i,
  input  logic       rx_bi_i,
  input  logic       rx_oe_i,
  input  logic       rx_fifo_err_i,
  input  logic       rx_empty_i,
  input  logic       tx_empty_i,
  input  logic       tx_shift_idle_i,
  input  logic       fcr_ena_i,
  input  ier_t       ier_i,
  input  logic       lsr_clr_i,
  input  logic       thre_set_i,
  input  logic       thre_clr_i,
  output lsr_t       lsr_o,
  output logic [7:0] iir_o,
  output logic       irq_o
);

  logic       oe_q, pe_q, fe_q, bi_q;
  logic       thre_pend_q;
  logic       tx_empty_q;
  logic       irq_q;
  logic [3:0] code;

  // Events arriving this cycle are visible immediately so a concurrent LSR read reports them.
  always_comb begin
    lsr_o               = '0;
    lsr_o.dr            = ~rx_empty_i;
    lsr_o.oe            = oe_q | rx_oe_i;
    lsr_o.pe            = pe_q | rx_pe_i;
    lsr_o.fe            = fe_q | rx_fe_i;
    lsr_o.bi            = bi_q | rx_bi_i;
    lsr_o.thre          = tx_empty_i;
    lsr_o.temt          = tx_empty_i & tx_shift_idle_i;
    lsr_o.rx_fifo_error = rx_fifo_err_i & fcr_ena_i;
  end

  always_comb begin
    code = IIR_NONE;
    if (ier_i.lsi && (lsr_o.oe || lsr_o.pe || lsr_o.fe || lsr_o.bi)) code = IIR_LSI;
    else if (ier_i.rdai && lsr_o.dr)                                 code = IIR_RDA;
    else if (ier_i.threi && thre_pend_q)                             code = IIR_THRE;
    iir_o = {{2{fcr_ena_i}}, 2'b00, code};
  end

  // A new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q        <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      bi_q        <= 1'b0;
      thre_pend_q <= 1'b0;
      tx_empty_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      oe_q        <= (oe_q & ~lsr_clr_i) | rx_oe_i;
      pe_q        <= (pe_q & ~lsr_clr_i) | rx_pe_i;
      fe_q        <= (fe_q & ~lsr_clr_i) | rx_fe_i;
      bi_q        <= (bi_q & ~lsr_clr_i) | rx_bi_i;
      thre_pend_q <= (thre_pend_q & ~thre_clr_i) | (tx_empty_i & ~tx_empty_q) | thre_set_i;
      tx_empty_q  <= tx_empty_i;
      irq_q       <= ~iir_o[0];
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/uart_reg_ctrl.sv
// 16550-style UART register controller: host register decode, CSR state and
// FIFO/baud sequencing pulses. Define UART_SCR_EN to implement the SCR register.
module uart_reg_ctrl
  import uart_reg_ctrl_pkg::*;
#(
  parameter logic [15:0] DIV_RST = 16'h0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  input  logic       req_write_i,
  input  logic [2:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       req_ready_o,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  input  logic [7:0] rx_data_i,
  input  logic       rx_empty_i,
  output logic       rx_pop_o,
  output logic [7:0] tx_data_o,
  output logic       tx_push_o,
  input  logic       tx_full_i,
  input  logic       tx_empty_i,
  input  logic       tx_shift_idle_i,
  input  logic       rx_pe_i,
  input  logic       rx_fe_i,
  input  logic       rx_bi_i,
  input  logic       rx_oe_i,
  input  logic       rx_fifo_err_i,
  output logic       fifo_rx_rst_o,
  output logic       fifo_tx_rst_o,
  output logic       div_load_o,
  output csr_t       csr_o,
  output div_t       div_o,
  output logic       irq_o
);

  rsp_state_e state_q, state_d;
  fcr_t       fcr_q;
  lcr_t       lcr_q;
  ier_t       ier_q;
  div_t       div_q;
  logic [7:0] rdata_q, tx_data_q, rd_data, iir, scr_val;
  logic       rx_pop_q, tx_push_q, frx_q, ftx_q, div_load_q, lsr_clr_q, thre_clr_q;
  logic       accept, dlab, thre_set;
  lsr_t       lsr;
  fcr_t       fcr_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        accept      = req_valid_i;
        if (req_valid_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dlab     = lcr_q.dlab;
  assign fcr_new  = fcr_store(req_wdata_i);
  assign thre_set = accept & req_write_i & ~dlab & (req_addr_i == UART_IER) &
                    ~ier_q.threi & req_wdata_i[1] & tx_empty_i;

  always_comb begin
    rd_data = '0;
    case (req_addr_i)
      UART_RBR: rd_data = dlab ? div_q.dll : (rx_empty_i ? 8'h00 : rx_data_i);
      UART_IER: rd_data = dlab ? div_q.dlm : {5'b0, ier_q};
      UART_IIR: rd_data = iir;
      UART_LCR: rd_data = lcr_q;
      UART_LSR: rd_data = lsr;
      UART_SCR: rd_data = scr_val;
      default:  rd_data = '0;
    endcase
  end

  // Accepted requests update state at the end of the accept cycle; pulses follow one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcr_q      <= '0;
      lcr_q      <= '0;
      ier_q      <= '0;
      div_q      <= DIV_RST;
      rdata_q    <= '0;
      tx_data_q  <= '0;
      rx_pop_q   <= 1'b0;
      tx_push_q  <= 1'b0;
      frx_q      <= 1'b0;
      ftx_q      <= 1'b0;
      div_load_q <= 1'b0;
      lsr_clr_q  <= 1'b0;
      thre_clr_q <= 1'b0;
    end else begin
      rdata_q    <= '0;
      rx_pop_q   <= 1'b0;
      tx_push_q  <= 1'b0;
      frx_q      <= 1'b0;
      ftx_q      <= 1'b0;
      div_load_q <= 1'b0;
      lsr_clr_q  <= 1'b0;
      thre_clr_q <= 1'b0;
      if (accept && req_write_i) begin
        case (req_addr_i)
          UART_THR: begin
            if (dlab) begin
              div_q.dll  <= req_wdata_i;
              div_load_q <= 1'b1;
            end else begin
              tx_data_q  <= req_wdata_i;
              tx_push_q  <= ~tx_full_i;
              thre_clr_q <= 1'b1;
            end
          end
          UART_IER: begin
            if (dlab) begin
              div_q.dlm  <= req_wdata_i;
              div_load_q <= 1'b1;
            end else begin
              ier_q <= req_wdata_i[2:0];
            end
          end
          UART_FCR: begin
            fcr_q <= fcr_new;
            frx_q <= req_wdata_i[1] | (fcr_new.ena != fcr_q.ena);
            ftx_q <= req_wdata_i[2] | (fcr_new.ena != fcr_q.ena);
          end
          UART_LCR: lcr_q <= req_wdata_i;
          default: ;
        endcase
      end else if (accept) begin
        rdata_q    <= rd_data;
        rx_pop_q   <= (req_addr_i == UART_RBR) & ~dlab & ~rx_empty_i;
        lsr_clr_q  <= (req_addr_i == UART_LSR);
        thre_clr_q <= (req_addr_i == UART_IIR) & (iir[3:0] == IIR_THRE);
      end
    end
  end

`ifdef UART_SCR_EN
  logic [7:0] scr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     scr_q <= '0;
    else if (accept && req_write_i && req_addr_i == UART_SCR)    scr_q <= req_wdata_i;
  end

  assign scr_val = scr_q;
`else
  assign scr_val = '0;
`endif

  uart_lsr_track u_lsr (
    .clk             (clk),
    .rst             (rst),
    .rx_pe_i         (rx_pe_i),
    .rx_fe_i         (rx_fe_i),
    .rx_bi_i         (rx_bi_i),
    .rx_oe_i         (rx_oe_i),
    .rx_fifo_err_i   (rx_fifo_err_i),
    .rx_empty_i      (rx_empty_i),
    .tx_empty_i      (tx_empty_i),
    .tx_shift_idle_i (tx_shift_idle_i),
    .fcr_ena_i       (fcr_q.ena),
    .ier_i           (ier_q),
    .lsr_clr_i       (lsr_clr_q),
    .thre_set_i      (thre_set),
    .thre_clr_i      (thre_clr_q),
    .lsr_o           (lsr),
    .iir_o           (iir),
    .irq_o           (irq_o)
  );

  assign rsp_rdata_o   = rdata_q;
  assign rx_pop_o      = rx_pop_q;
  assign tx_push_o     = tx_push_q;
  assign tx_data_o     = tx_data_q;
  assign fifo_rx_rst_o = frx_q;
  assign fifo_tx_rst_o = ftx_q;
  assign div_load_o    = div_load_q;
  assign div_o         = div_q;
  assign csr_o.fcr     = fcr_q;
  assign csr_o.lcr     = lcr_q;
  assign csr_o.lsr     = lsr;
  assign csr_o.scr     = scr_val;

endmodule
